// File: rtl/uart_tx_periph.sv
// uart_tx_periph: memory-mapped UART transmitter sitting on the data-side bus.
// Stores to TXDATA queue bytes into a small FIFO; a bit-timing FSM pops them
// and shifts them out LSB first as 8N1 frames (8E1 with UART_TX_PARITY_EN).
//
// Build option:
//   UART_TX_PARITY_EN  adds an even-parity bit between data bit 7 and stop.
//
// Ports:
//   clk_i    core clock
//   rst_i    synchronous active-high reset
//   we       store strobe
//   cs       chip select, active-low
//   addr_i   byte address, [3:2] selects TXDATA/STATUS/CTRL/reserved
//   wdata_i  store data
//   rdata_o  read data (0 when not selected)
//   tx_o     serial line, idle high, driven from a flop
//
// state  | meaning
// S_IDLE | line idle (high), waiting for en and a queued byte
// S_START| start bit (low)
// S_DATA | data bit bit_idx, LSB first
// S_PARITY| even parity bit (parity build only)
// S_STOP | stop bit (high); may chain straight into the next START
module uart_tx_periph #(
   parameter int DW           = 32,
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we,
   input  logic          cs,
   input  logic [DW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic          tx_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   FIFO_FULL   = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   fifo_cnt;
   logic          ovf;
   logic          en;
   state_t        state;
   logic [BW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [2:0]    next_idx;
   logic [7:0]    data_reg;

   logic sel;
   logic wr_txdata;
   logic wr_status;
   logic wr_ctrl;
   logic fifo_empty;
   logic fifo_full;
   logic push;
   logic pop;
   logic baud_tc;
   logic busy;
   logic unused_bits;

   assign sel        = ~cs;
   assign wr_txdata  = sel & we & (addr_i[3:2] == 2'd0);
   assign wr_status  = sel & we & (addr_i[3:2] == 2'd1);
   assign wr_ctrl    = sel & we & (addr_i[3:2] == 2'd2);
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == FIFO_FULL);
   assign baud_tc    = (baud_cnt == '0);
   assign busy       = (state != S_IDLE);
   assign next_idx   = bit_idx + 3'd1;

   // Fullness is judged on the count before the edge, so a pop on the same
   // edge never frees a slot for the incoming write.
   assign push = wr_txdata & ~fifo_full;
   // A frame is launched from idle, or chained from the last cycle of STOP.
   assign pop  = en & ~fifo_empty &
                 ((state == S_IDLE) | ((state == S_STOP) & baud_tc));

   assign unused_bits = ^{addr_i[DW-1:4], addr_i[1:0], wdata_i[DW-1:8]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= wdata_i[7:0];
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ovf <= 1'b0;
         en  <= 1'b1;
      end else begin
         if (wr_txdata & fifo_full) begin
            ovf <= 1'b1;
         end else if (wr_status) begin
            ovf <= 1'b0;
         end
         if (wr_ctrl) begin
            en <= wdata_i[0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         tx_o     <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         data_reg <= '0;
      end else begin
         // Down-count toward terminal count; every transition below reloads.
         if (!baud_tc) begin
            baud_cnt <= baud_cnt - 1'b1;
         end
         case (state)
            S_IDLE: begin
               tx_o <= 1'b1;
               if (pop) begin
                  state    <= S_START;
                  tx_o     <= 1'b0;
                  baud_cnt <= BAUD_RELOAD;
                  data_reg <= fifo_mem[rd_ptr];
               end
            end
            S_START: begin
               if (baud_tc) begin
                  state    <= S_DATA;
                  bit_idx  <= '0;
                  tx_o     <= data_reg[0];
                  baud_cnt <= BAUD_RELOAD;
               end
            end
            S_DATA: begin
               if (baud_tc) begin
                  baud_cnt <= BAUD_RELOAD;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= S_PARITY;
                     tx_o  <= ^data_reg;
`else
                     state <= S_STOP;
                     tx_o  <= 1'b1;
`endif
                  end else begin
                     bit_idx <= next_idx;
                     tx_o    <= data_reg[next_idx];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (baud_tc) begin
                  state    <= S_STOP;
                  tx_o     <= 1'b1;
                  baud_cnt <= BAUD_RELOAD;
               end
            end
`endif
            S_STOP: begin
               if (baud_tc) begin
                  if (pop) begin
                     state    <= S_START;
                     tx_o     <= 1'b0;
                     baud_cnt <= BAUD_RELOAD;
                     data_reg <= fifo_mem[rd_ptr];
                  end else begin
                     state <= S_IDLE;
                     tx_o  <= 1'b1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               tx_o  <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      rdata_o = '0;
      if (sel) begin
         case (addr_i[3:2])
            2'd1:    rdata_o[3:0] = {ovf, fifo_empty, fifo_full, busy};
            2'd2:    rdata_o[0]   = en;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_periph.sv
module tb_uart_tx_periph;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NSLOT = 11;
`else
   localparam int NSLOT = 10;
`endif
   localparam int FL = NSLOT * CPB;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic        cs;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        tx;

   always #5 clk = ~clk;

   uart_tx_periph #(
      .DW          (32),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .we     (we),
      .cs     (cs),
      .addr_i (addr),
      .wdata_i(wdata),
      .rdata_o(rdata),
      .tx_o   (tx)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: a byte queue plus the frame currently on the wire,
   // described as a slot vector and a cycle position inside the frame.
   logic [7:0]  m_q[$];
   logic        m_ovf;
   logic        m_en;
   logic        m_active;
   int          m_pos;
   logic [10:0] m_bits;

   function automatic logic [10:0] frame_bits(input logic [7:0] d);
      logic [10:0] b;
      b      = '1;
      b[0]   = 1'b0;
      b[8:1] = d;
`ifdef UART_TX_PARITY_EN
      b[9]   = ^d;
`endif
      return b;
   endfunction

   task automatic model_step(input logic r, input logic w, input logic c,
                             input logic [31:0] a, input logic [31:0] d);
      int   pre;
      logic do_pop;
      if (r) begin
         m_q.delete();
         m_ovf = 1'b0; m_en = 1'b1; m_active = 1'b0; m_pos = 0; m_bits = '1;
         return;
      end
      pre    = m_q.size();
      do_pop = 1'b0;
      if (!m_active) begin
         do_pop = m_en && (pre > 0);
      end else if (m_pos == FL - 1) begin
         do_pop = m_en && (pre > 0);
         if (!do_pop) m_active = 1'b0;
      end else begin
         m_pos++;
      end
      if (do_pop) begin
         m_bits   = frame_bits(m_q.pop_front());
         m_active = 1'b1;
         m_pos    = 0;
      end
      if (w && !c) begin
         case (a[3:2])
            2'd0: if (pre == DEPTH) m_ovf = 1'b1; else m_q.push_back(d[7:0]);
            2'd1: m_ovf = 1'b0;
            2'd2: m_en = d[0];
            default: ;
         endcase
      end
   endtask

   function automatic logic model_tx();
      return m_active ? m_bits[m_pos / CPB] : 1'b1;
   endfunction

   function automatic logic [31:0] model_rdata(input logic c, input logic [31:0] a);
      logic [31:0] v;
      v = '0;
      if (!c) begin
         case (a[3:2])
            2'd1: v[3:0] = {m_ovf, m_q.size() == 0, m_q.size() == DEPTH, m_active};
            2'd2: v[0]   = m_en;
            default: ;
         endcase
      end
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One bus cycle: drive, check read data against the pre-edge model,
   // clock, advance the model, check the line.
   task automatic cycle(input logic r, input logic w, input logic c,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
      rst = r; we = w; cs = c; addr = a; wdata = d;
      #1;
      rd = rdata;
      if (!r) check("rdata", rdata, model_rdata(c, a));
      @(posedge clk);
      model_step(r, w, c, a, d);
      #1;
      check("tx_o", {31'b0, tx}, {31'b0, model_tx()});
   endtask

   typedef struct {
      logic        w;
      logic        c;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl[16];

   logic [31:0]      rd;
   logic [NSLOT-1:0] got;
   logic [NSLOT-1:0] exp_frame;
   int               first_idle;

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 32'h4,   32'h0,        32'h4};
      tbl[1]  = '{1'b0, 1'b0, 32'h0,   32'h0,        32'h0};
      tbl[2]  = '{1'b0, 1'b0, 32'h8,   32'h0,        32'h1};
      tbl[3]  = '{1'b0, 1'b0, 32'hC,   32'h0,        32'h0};
      tbl[4]  = '{1'b0, 1'b1, 32'h4,   32'h0,        32'h0};
      tbl[5]  = '{1'b1, 1'b0, 32'h8,   32'h0,        32'h1};
      tbl[6]  = '{1'b0, 1'b0, 32'h8,   32'h0,        32'h0};
      tbl[7]  = '{1'b1, 1'b1, 32'h8,   32'h1,        32'h0};
      tbl[8]  = '{1'b0, 1'b0, 32'h8,   32'h0,        32'h0};
      tbl[9]  = '{1'b1, 1'b0, 32'h8,   32'hFFFFFFFF, 32'h0};
      tbl[10] = '{1'b0, 1'b0, 32'h8,   32'h0,        32'h1};
      tbl[11] = '{1'b1, 1'b0, 32'hC,   32'hFF,       32'h0};
      tbl[12] = '{1'b0, 1'b0, 32'h4,   32'h0,        32'h4};
      tbl[13] = '{1'b1, 1'b0, 32'h4,   32'h0,        32'h4};
      tbl[14] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'h4};
      tbl[15] = '{1'b0, 1'b0, 32'h9,   32'h0,        32'h1};

      cycle(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, rd);
      cycle(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, rd);

      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, tbl[i].w, tbl[i].c, tbl[i].a, tbl[i].d, rd);
         check("tbl_rdata", rd, tbl[i].exp_rd);
      end

      // Single 0xA5 frame: sample each slot mid-bit.
`ifdef UART_TX_PARITY_EN
      exp_frame = 11'b1_0_10100101_0;
`else
      exp_frame = 10'b1_10100101_0;
`endif
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'hA5, rd);
      got = '0;
      for (int j = 0; j < FL; j++) begin
         cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
         if (j % CPB == 1) got[j / CPB] = tx;
      end
      check("a5_frame", {{(32-NSLOT){1'b0}}, got}, {{(32-NSLOT){1'b0}}, exp_frame});
      cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
      check("a5_busy_last", rd, 32'h5);
      cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
      check("a5_idle", rd, 32'h4);

      // Six back-to-back writes: one launches, four fill, one overflows.
      for (int j = 0; j < 6; j++) begin
         cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h11 * (j + 1), rd);
      end
      first_idle = -1;
      for (int i = 0; i < 6 * FL; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
         if (i == 0) check("ovf_status", rd, 32'hB);
         if (rd[0] == 1'b0) begin
            first_idle = i;
            check("ovf_after_frames", rd, 32'hC);
            break;
         end
      end
      check("five_frames_len", first_idle, 5 * FL - 4);
      cycle(1'b0, 1'b1, 1'b0, 32'h4, 32'h1234, rd);
      cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
      check("ovf_cleared", rd, 32'h4);

      // Disable mid-frame with two bytes queued, then resume.
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h31, rd);
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h32, rd);
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h33, rd);
      for (int j = 0; j < 12; j++) cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
      cycle(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, rd);
      for (int j = 0; j < 2 * FL; j++) cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
      cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
      check("disabled_status", rd, 32'h0);
      cycle(1'b0, 1'b1, 1'b0, 32'h8, 32'h1, rd);
      for (int j = 0; j < 2 * FL + 8; j++) cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
      cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
      check("resumed_drained", rd, 32'h4);

      // Reset during data bit 3, then a deselected write.
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h5A, rd);
      for (int j = 0; j < 17; j++) cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
      cycle(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, rd);
      check("rst_tx", {31'b0, tx}, 32'h1);
      cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
      check("rst_status", rd, 32'h4);
      cycle(1'b0, 1'b1, 1'b1, 32'h0, 32'h77, rd);
      check("cs_high_rdata", rd, 32'h0);
      cycle(1'b0, 1'b0, 1'b0, 32'h4, 32'h0, rd);
      check("cs_high_ignored", rd, 32'h4);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic        r_r, r_w, r_c;
         logic [31:0] r_a, r_d;
         int          s;
         r_r = ($urandom_range(0, 499) == 0);
         r_w = ($urandom_range(0, 3) == 0);
         r_c = ($urandom_range(0, 4) == 0);
         r_a = $urandom;
         r_d = $urandom;
         s   = $urandom_range(0, 9);
         if (s <= 5)      r_a[3:2] = 2'd0;
         else if (s <= 7) r_a[3:2] = 2'd1;
         else if (s == 8) begin
            r_a[3:2] = 2'd2;
            r_d[0]   = ($urandom_range(0, 3) != 0);
         end else         r_a[3:2] = 2'd3;
         cycle(r_r, r_w, r_c, r_a, r_d, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
